regfile_access_ctrl: RTL and testbench

//  Initiator side of the 16-bit CPU register-file port. Takes decoded operand requests (rs1/rs2/rd) from decode.

---
 rtl/regfile_pkg.sv | 8 +
 rtl/regfile_scoreboard.sv | 35 +++
 rtl/regfile_access_ctrl.sv | 159 +++++++++++++++
 tb/tb_regfile_access_ctrl.sv | 399 +++++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/regfile_pkg.sv
// Shared widths and FSM encoding for the register-file access controller.
package regfile_pkg;
    localparam int DATA_W = 16;
    localparam int ADR_W  = 2;
    localparam int NREG   = 2 ** ADR_W;

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, HOLD} state_t;
endpackage

// File: rtl/regfile_scoreboard.sv
// Pending-write mask: one bit per register, set on dispatch, cleared on writeback.
module regfile_scoreboard
    import regfile_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    input  logic             set_en,
    input  logic [ADR_W-1:0] set_adr,
    input  logic             clr_en,
    input  logic [ADR_W-1:0] clr_adr,
    input  logic [ADR_W-1:0] adr1,
    input  logic [ADR_W-1:0] adr2,
    input  logic [ADR_W-1:0] adr3,
    output logic             hit1,
    output logic             hit2,
    output logic             hit3,
    output logic [NREG-1:0]  pending
);
    logic [NREG-1:0] set_mask;
    logic [NREG-1:0] clr_mask;

    always_comb begin
        set_mask = set_en ? (NREG'(1) << set_adr) : '0;
        clr_mask = clr_en ? (NREG'(1) << clr_adr) : '0;
        hit1     = pending[adr1];
        hit2     = pending[adr2];
        hit3     = pending[adr3];
    end

    // OR-ing the set mask after the clear makes a same-cycle set win.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) pending <= '0;
        else        pending <= (pending & ~clr_mask) | set_mask;
    end
endmodule

// File: rtl/regfile_access_ctrl.sv
// Register-file read/issue controller with pending-write interlock.
// Optional writeback forwarding is enabled by defining WB_BYPASS_EN.
module regfile_access_ctrl
    import regfile_pkg::*;
(
    input  logic              clk,
    input  logic              reset,
    input  logic              in_valid,
    output logic              in_ready,
    input  logic [ADR_W-1:0]  in_rs1,
    input  logic [ADR_W-1:0]  in_rs2,
    input  logic [ADR_W-1:0]  in_rd,
    input  logic              in_wr,
    output logic              out_valid,
    input  logic              out_ready,
    output logic [DATA_W-1:0] out_op1,
    output logic [DATA_W-1:0] out_op2,
    output logic [ADR_W-1:0]  out_rd,
    output logic              out_wr,
    input  logic              wb_valid,
    input  logic [ADR_W-1:0]  wb_adr,
    input  logic [DATA_W-1:0] wb_data,
    output logic              read_en,
    output logic [ADR_W-1:0]  read_adr1,
    output logic [ADR_W-1:0]  read_adr2,
    input  logic [DATA_W-1:0] read_data1,
    input  logic [DATA_W-1:0] read_data2,
    output logic              write_en,
    output logic [ADR_W-1:0]  write_adr,
    output logic [DATA_W-1:0] write_data,
    output logic [NREG-1:0]   pending
);
    state_t            state, state_nxt;
    logic [ADR_W-1:0]  rs1_q, rs2_q, rd_q;
    logic              wr_q;
    logic              p1, p2, p3;
    logic              hazard, accept;
    logic [DATA_W-1:0] src1, src2;

    regfile_scoreboard u_sb (
        .clk     (clk),
        .reset   (reset),
        .set_en  (out_valid & out_ready & out_wr),
        .set_adr (out_rd),
        .clr_en  (write_en),
        .clr_adr (write_adr),
        .adr1    (in_rs1),
        .adr2    (in_rs2),
        .adr3    (in_rd),
        .hit1    (p1),
        .hit2    (p2),
        .hit3    (p3),
        .pending (pending)
    );

`ifdef WB_BYPASS_EN
    logic              byp_vld;
    logic [ADR_W-1:0]  byp_adr;
    logic [DATA_W-1:0] byp_data;
    logic              wb_hit1, wb_hit2, wb_hit3;

    // A writeback landing this cycle resolves the matching pending bit.
    always_comb begin
        wb_hit1 = wb_valid && (wb_adr == in_rs1);
        wb_hit2 = wb_valid && (wb_adr == in_rs2);
        wb_hit3 = wb_valid && (wb_adr == in_rd);
        hazard  = (p1 && !wb_hit1) || (p2 && !wb_hit2) || (in_wr && p3 && !wb_hit3);
    end

    // Newest value first: live write port, then the value caught at accept.
    always_comb begin
        if (write_en && write_adr == rs1_q)      src1 = write_data;
        else if (byp_vld && byp_adr == rs1_q)    src1 = byp_data;
        else                                     src1 = read_data1;
        if (write_en && write_adr == rs2_q)      src2 = write_data;
        else if (byp_vld && byp_adr == rs2_q)    src2 = byp_data;
        else                                     src2 = read_data2;
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            byp_vld  <= 1'b0;
            byp_adr  <= '0;
            byp_data <= '0;
        end else if (accept) begin
            byp_vld  <= (p1 && wb_hit1) || (p2 && wb_hit2);
            byp_adr  <= wb_adr;
            byp_data <= wb_data;
        end
    end
`else
    always_comb begin
        hazard = p1 || p2 || (in_wr && p3);
        src1   = read_data1;
        src2   = read_data2;
    end
`endif

    always_comb begin
        state_nxt = state;
        in_ready  = 1'b0;
        read_en   = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE: begin
                in_ready = !hazard;
                if (in_valid && !hazard) state_nxt = ISSUE;
            end
            ISSUE: begin
                read_en   = 1'b1;
                state_nxt = WAIT;
            end
            WAIT:  state_nxt = HOLD;
            HOLD: begin
                out_valid = 1'b1;
                if (out_ready) state_nxt = IDLE;
            end
            default: state_nxt = IDLE;
        endcase
    end

    assign accept    = in_valid && in_ready;
    assign read_adr1 = rs1_q;
    assign read_adr2 = rs2_q;
    assign out_rd    = rd_q;
    assign out_wr    = wr_q;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            rs1_q      <= '0;
            rs2_q      <= '0;
            rd_q       <= '0;
            wr_q       <= 1'b0;
            out_op1    <= '0;
            out_op2    <= '0;
            write_en   <= 1'b0;
            write_adr  <= '0;
            write_data <= '0;
        end else begin
            state <= state_nxt;
            if (accept) begin
                rs1_q <= in_rs1;
                rs2_q <= in_rs2;
                rd_q  <= in_rd;
                wr_q  <= in_wr;
            end
            if (state == WAIT) begin
                out_op1 <= src1;
                out_op2 <= src2;
            end
            write_en <= wb_valid;
            if (wb_valid) begin
                write_adr  <= wb_adr;
                write_data <= wb_data;
            end
        end
    end
endmodule

// File: tb/tb_regfile_access_ctrl.sv
// Scoreboard bench for regfile_access_ctrl with a behavioural register file.
module tb_regfile_access_ctrl;
    import regfile_pkg::*;

    logic              clk = 1'b0;
    logic              reset = 1'b0;
    logic              in_valid = 1'b0, in_ready;
    logic [ADR_W-1:0]  in_rs1 = '0, in_rs2 = '0, in_rd = '0;
    logic              in_wr = 1'b0;
    logic              out_valid, out_ready = 1'b1;
    logic [DATA_W-1:0] out_op1, out_op2;
    logic [ADR_W-1:0]  out_rd;
    logic              out_wr;
    logic              wb_valid = 1'b0;
    logic [ADR_W-1:0]  wb_adr = '0;
    logic [DATA_W-1:0] wb_data = '0;
    logic              read_en;
    logic [ADR_W-1:0]  read_adr1, read_adr2;
    logic [DATA_W-1:0] read_data1 = '0, read_data2 = '0;
    logic              write_en;
    logic [ADR_W-1:0]  write_adr;
    logic [DATA_W-1:0] write_data;
    logic [NREG-1:0]   pending;

    logic [DATA_W-1:0] rf [NREG] = '{default: '0};

    typedef struct packed {
        logic [DATA_W-1:0] op1;
        logic [DATA_W-1:0] op2;
        logic [ADR_W-1:0]  rd;
        logic              wr;
    } exp_t;
    exp_t exp_q[$];
    int   vectors = 0;
    int   errors = 0;
    int   st;

    always #5 clk = ~clk;

    regfile_access_ctrl dut (
        .clk(clk), .reset(reset),
        .in_valid(in_valid), .in_ready(in_ready), .in_rs1(in_rs1), .in_rs2(in_rs2),
        .in_rd(in_rd), .in_wr(in_wr),
        .out_valid(out_valid), .out_ready(out_ready), .out_op1(out_op1), .out_op2(out_op2),
        .out_rd(out_rd), .out_wr(out_wr),
        .wb_valid(wb_valid), .wb_adr(wb_adr), .wb_data(wb_data),
        .read_en(read_en), .read_adr1(read_adr1), .read_adr2(read_adr2),
        .read_data1(read_data1), .read_data2(read_data2),
        .write_en(write_en), .write_adr(write_adr), .write_data(write_data),
        .pending(pending)
    );

    // Synchronous-read register file: data one cycle after read_en, read-before-write.
    always @(posedge clk) begin
        if (read_en) begin
            read_data1 <= rf[read_adr1];
            read_data2 <= rf[read_adr2];
        end
        if (write_en) rf[write_adr] <= write_data;
    end

    // Output monitor: every ALU handshake pops one expectation.
    always @(negedge clk) begin
        exp_t e;
        if (reset && out_valid && out_ready) begin
            vectors++;
            if (exp_q.size() == 0) begin
                errors++;
                $display("FAIL out_unexpected got op1=%h op2=%h rd=%0d wr=%0b want none",
                         out_op1, out_op2, out_rd, out_wr);
            end else begin
                e = exp_q.pop_front();
                if ({out_op1, out_op2, out_rd, out_wr} !== e) begin
                    errors++;
                    $display("FAIL out_data got op1=%h op2=%h rd=%0d wr=%0b want op1=%h op2=%h rd=%0d wr=%0b",
                             out_op1, out_op2, out_rd, out_wr, e.op1, e.op2, e.rd, e.wr);
                end
            end
        end
    end

    initial begin
        #50000;
        $display("FAIL watchdog got timeout want finish");
        $fatal(1);
    end

    task automatic step;
        @(posedge clk);
        #1;
    endtask

    task automatic issue(input logic [ADR_W-1:0] a1, input logic [ADR_W-1:0] a2,
                         input logic [ADR_W-1:0] d, input logic w,
                         input logic [DATA_W-1:0] e1, input logic [DATA_W-1:0] e2,
                         input bit push, output int stall);
        in_valid = 1'b1; in_rs1 = a1; in_rs2 = a2; in_rd = d; in_wr = w;
        stall = 0;
        @(negedge clk);
        while (!in_ready && stall < 40) begin
            step;
            @(negedge clk);
            stall++;
        end
        if (!in_ready) begin
            vectors++; errors++;
            $display("FAIL accept_timeout got in_ready=0 want 1");
        end else if (push) begin
            exp_q.push_back(exp_t'({e1, e2, d, w}));
        end
        step;
        in_valid = 1'b0;
    endtask

    task automatic drain;
        int n = 0;
        while (exp_q.size() != 0 && n < 30) begin
            step;
            n++;
        end
        vectors++;
        if (exp_q.size() != 0) begin
            errors++;
            $display("FAIL drain got %0d outstanding want 0", exp_q.size());
        end
    endtask

    task automatic wb(input logic [ADR_W-1:0] a, input logic [DATA_W-1:0] dt);
        wb_valid = 1'b1; wb_adr = a; wb_data = dt;
        step;
        wb_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({write_en, write_adr, write_data} !== {1'b1, a, dt}) begin
            errors++;
            $display("FAIL wb_pulse got en=%0b adr=%0d data=%h want en=1 adr=%0d data=%h",
                     write_en, write_adr, write_data, a, dt);
        end
        step;
    endtask

    task automatic test_reset;
        #12;
        vectors++;
        if ({in_ready, out_valid, read_en, write_en, pending, out_op1, out_op2, write_data,
             write_adr, read_adr1, read_adr2, out_rd, out_wr} !== {1'b1, {(3+NREG+3*DATA_W+4*ADR_W+1){1'b0}}}) begin
            errors++;
            $display("FAIL reset_state got rdy=%0b ov=%0b re=%0b we=%0b pend=%b op1=%h want rdy=1 rest=0",
                     in_ready, out_valid, read_en, write_en, pending, out_op1);
        end
        step;
        reset = 1'b1;
        step;
    endtask

    task automatic test_back_to_back;
        wb_valid = 1'b1; wb_adr = 2'd0; wb_data = 16'hCCCC;
        step;
        wb_adr = 2'd1; wb_data = 16'hAAAA;
        @(negedge clk);
        vectors++;
        if ({write_en, write_adr, write_data} !== {1'b1, 2'd0, 16'hCCCC}) begin
            errors++;
            $display("FAIL b2b_first got en=%0b adr=%0d data=%h want 1/0/cccc", write_en, write_adr, write_data);
        end
        step;
        wb_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({write_en, write_adr, write_data} !== {1'b1, 2'd1, 16'hAAAA}) begin
            errors++;
            $display("FAIL b2b_second got en=%0b adr=%0d data=%h want 1/1/aaaa", write_en, write_adr, write_data);
        end
        step;
        @(negedge clk);
        vectors++;
        if ({write_en, write_adr, write_data, pending} !== {1'b0, 2'd1, 16'hAAAA, 4'b0000}) begin
            errors++;
            $display("FAIL b2b_idle got en=%0b adr=%0d data=%h pend=%b want 0/1/aaaa/0000",
                     write_en, write_adr, write_data, pending);
        end
        step;
    endtask

    task automatic test_basic;
        out_ready = 1'b1;
        issue(2'd0, 2'd1, 2'd0, 1'b0, 16'hCCCC, 16'hAAAA, 1'b1, st);
        @(negedge clk);
        vectors++;
        if ({read_en, read_adr1, read_adr2, out_valid} !== {1'b1, 2'd0, 2'd1, 1'b0}) begin
            errors++;
            $display("FAIL basic_issue got re=%0b a1=%0d a2=%0d ov=%0b want 1/0/1/0",
                     read_en, read_adr1, read_adr2, out_valid);
        end
        step;
        @(negedge clk);
        vectors++;
        if ({read_en, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL basic_wait got re=%0b ov=%0b want 0/0", read_en, out_valid);
        end
        step;
        @(negedge clk);
        vectors++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL basic_latency got ov=%0b want 1", out_valid);
        end
        step;
        drain;
    endtask

    task automatic test_hazard;
        issue(2'd0, 2'd0, 2'd2, 1'b1, 16'hCCCC, 16'hCCCC, 1'b1, st);
        drain;
        @(negedge clk);
        vectors++;
        if (pending !== 4'b0100) begin
            errors++;
            $display("FAIL hazard_set got pend=%b want 0100", pending);
        end
        step;
        fork
            issue(2'd2, 2'd1, 2'd0, 1'b0, 16'hFFFF, 16'hAAAA, 1'b1, st);
            begin
                for (int i = 0; i < 3; i++) begin
                    @(negedge clk);
                    vectors++;
                    if (in_ready !== 1'b0) begin
                        errors++;
                        $display("FAIL hazard_stall got in_ready=%0b want 0", in_ready);
                    end
                    step;
                end
                wb(2'd2, 16'hFFFF);
            end
        join
        vectors++;
`ifdef WB_BYPASS_EN
        if (st != 3) begin
`else
        if (st != 5) begin
`endif
            errors++;
            $display("FAIL hazard_stall_len got %0d", st);
        end
        @(negedge clk);
        vectors++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL hazard_clear got pend=%b want 0000", pending);
        end
        step;
        drain;
    endtask

    task automatic test_hold;
        out_ready = 1'b0;
        issue(2'd1, 2'd0, 2'd0, 1'b0, 16'hAAAA, 16'hCCCC, 1'b1, st);
        step;
        step;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, out_op1, out_op2, in_ready} !== {1'b1, 16'hAAAA, 16'hCCCC, 1'b0}) begin
                errors++;
                $display("FAIL hold_stable got ov=%0b op1=%h op2=%h rdy=%0b want 1/aaaa/cccc/0",
                         out_valid, out_op1, out_op2, in_ready);
            end
            step;
        end
        out_ready = 1'b1;
        step;
        @(negedge clk);
        vectors++;
        if ({out_valid, in_ready} !== 2'b01) begin
            errors++;
            $display("FAIL hold_release got ov=%0b rdy=%0b want 0/1", out_valid, in_ready);
        end
        step;
        drain;
    endtask

    task automatic test_set_wins;
        issue(2'd0, 2'd0, 2'd3, 1'b1, 16'hCCCC, 16'hCCCC, 1'b1, st);
        step;
        wb_valid = 1'b1; wb_adr = 2'd3; wb_data = 16'h5555;
        step;
        wb_valid = 1'b0;
        @(negedge clk);
        vectors++;
        if ({out_valid, write_en, write_adr} !== {1'b1, 1'b1, 2'd3}) begin
            errors++;
            $display("FAIL setwin_align got ov=%0b we=%0b wadr=%0d want 1/1/3", out_valid, write_en, write_adr);
        end
        step;
        @(negedge clk);
        vectors++;
        if (pending !== 4'b1000) begin
            errors++;
            $display("FAIL setwin_pend got pend=%b want 1000", pending);
        end
        step;
    endtask

    task automatic test_reset_wait;
        issue(2'd0, 2'd1, 2'd0, 1'b0, 16'h0000, 16'h0000, 1'b0, st);
        wb_valid = 1'b1; wb_adr = 2'd0; wb_data = 16'hCCCC;
        step;
        wb_valid = 1'b0;
        reset = 1'b0;
        #1;
        vectors++;
        if ({read_en, write_en, out_valid, pending, in_ready} !== {3'b000, 4'b0000, 1'b1}) begin
            errors++;
            $display("FAIL rst_wait got re=%0b we=%0b ov=%0b pend=%b rdy=%0b want 0/0/0/0000/1",
                     read_en, write_en, out_valid, pending, in_ready);
        end
        step;
        step;
        reset = 1'b1;
        for (int i = 0; i < 5; i++) begin
            @(negedge clk);
            vectors++;
            if ({out_valid, read_en, out_op1, out_op2} !== {2'b00, 32'h0}) begin
                errors++;
                $display("FAIL rst_nocapture got ov=%0b re=%0b op1=%h op2=%h want 0/0/0/0",
                         out_valid, read_en, out_op1, out_op2);
            end
            step;
        end
    endtask

    task automatic test_bypass;
        issue(2'd0, 2'd0, 2'd2, 1'b1, 16'hCCCC, 16'hCCCC, 1'b1, st);
        drain;
        step;
        fork
            issue(2'd2, 2'd0, 2'd0, 1'b0, 16'h1234, 16'hCCCC, 1'b1, st);
            wb(2'd2, 16'h1234);
        join
        vectors++;
`ifdef WB_BYPASS_EN
        if (st != 0) begin
`else
        if (st != 2) begin
`endif
            errors++;
            $display("FAIL bypass_stall got %0d", st);
        end
        drain;
        @(negedge clk);
        vectors++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL bypass_pend got pend=%b want 0000", pending);
        end
        step;
    endtask

    task automatic test_same_addr;
        issue(2'd1, 2'd1, 2'd1, 1'b1, 16'hAAAA, 16'hAAAA, 1'b1, st);
        vectors++;
        if (st != 0) begin
            errors++;
            $display("FAIL same_addr_stall got %0d want 0", st);
        end
        drain;
        @(negedge clk);
        vectors++;
        if (pending !== 4'b0010) begin
            errors++;
            $display("FAIL same_addr_pend got pend=%b want 0010", pending);
        end
        step;
        wb(2'd1, 16'hAAAA);
        @(negedge clk);
        vectors++;
        if (pending !== 4'b0000) begin
            errors++;
            $display("FAIL same_addr_clear got pend=%b want 0000", pending);
        end
        step;
    endtask

    initial begin
        test_reset;
        test_back_to_back;
        test_basic;
        test_hazard;
        test_hold;
        test_set_wins;
        test_reset_wait;
        test_bypass;
        test_same_addr;
        $display("== %0d vectors applied, %0d miscompares ==", vectors, errors);
        $finish;
    end
endmodule
